pagerank_feeder: RTL

PAGERANK_FEEDER -- requirements
Module: pagerank_feeder

---
 rtl/pagerank_feeder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pagerank_feeder.sv
// pagerank_feeder: streams one PageRank iteration's (rank, out-degree) pairs
// from two BRAMs into a parallel divider.
//
// Optional feature (macro ZERO_DEG_SUBST_EN): a dangling node's out-degree
// of 0 is replaced by the zero-extended node count on out_deg_bram.
// Without the macro, the 0 passes through unchanged.
//
// Ports:
//   clk, reset               - single clock; synchronous active-high reset
//   start, node_count        - one-cycle iteration request and node count,
//                              both sampled in IDLE
//   pr_addr/pr_rdata         - page-rank BRAM port (one cycle read latency)
//   deg_addr/deg_rdata       - out-degree BRAM port (address mirrors pr_addr)
//   page_rank_bram           - registered dividend to the divider
//   out_deg_bram             - registered divisor to the divider
//   ip_count                 - latched node count presented to the divider
//   div_valid, zero_deg      - pair qualifier; flags a zero out-degree
//   done_parrallel_division  - completion from the divider
//   busy, feed_done          - iteration in progress; end-of-iteration pulse
module pagerank_feeder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] node_count,
  output logic [ADDR_W-1:0] pr_addr,
  input  logic [DATA_W-1:0] pr_rdata,
  output logic [ADDR_W-1:0] deg_addr,
  input  logic [DATA_W-1:0] deg_rdata,
  output logic [DATA_W-1:0] page_rank_bram,
  output logic [DATA_W-1:0] out_deg_bram,
  output logic [ADDR_W-1:0] ip_count,
  output logic              div_valid,
  input  logic              done_parrallel_division,
  output logic              busy,
  output logic              feed_done,
  output logic              zero_deg
);

  typedef enum logic [2:0] {StIdle, StRead, StStream, StWaitDiv, StDone} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   ip_count_q;
  logic                issuing_q;  // addresses still being issued in STREAM
  logic                rd_vld_q;   // BRAM read data this cycle belongs to a node
  logic                issue;
  logic [DATA_W-1:0]   deg_subst;

  // An address is a real read in READ (node 0) and while STREAM still issues.
  always_comb begin
    issue = 1'b0;
    if (state_q == StRead) issue = 1'b1;
    else if (state_q == StStream && issuing_q) issue = 1'b1;
  end

`ifdef ZERO_DEG_SUBST_EN
  assign deg_subst = {{(DATA_W-ADDR_W){1'b0}}, ip_count_q};
`else
  assign deg_subst = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      ip_count_q     <= '0;
      issuing_q      <= 1'b0;
      rd_vld_q       <= 1'b0;
      div_valid      <= 1'b0;
      page_rank_bram <= '0;
      out_deg_bram   <= '0;
      zero_deg       <= 1'b0;
      busy           <= 1'b0;
      feed_done      <= 1'b0;
    end else begin
      // Read pipeline: address -> BRAM data -> output register.
      rd_vld_q  <= issue;
      div_valid <= rd_vld_q;
      zero_deg  <= rd_vld_q && (deg_rdata == '0);
      if (rd_vld_q) begin
        page_rank_bram <= pr_rdata;
        out_deg_bram   <= (deg_rdata == '0) ? deg_subst : deg_rdata;
      end
      feed_done <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            ip_count_q <= node_count;
            addr_q     <= '0;
            busy       <= 1'b1;
            if (node_count == '0) begin
              state_q   <= StDone;
              feed_done <= 1'b1;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (ip_count_q == ADDR_W'(1)) begin
            issuing_q <= 1'b0;
          end else begin
            issuing_q <= 1'b1;
            addr_q    <= addr_q + ADDR_W'(1);
          end
          state_q <= StStream;
        end
        StStream: begin
          if (issuing_q) begin
            // Hold the last address once node ip_count-1 has been issued.
            if (addr_q == ip_count_q - ADDR_W'(1)) issuing_q <= 1'b0;
            else                                   addr_q    <= addr_q + ADDR_W'(1);
          end else if (!rd_vld_q && div_valid) begin
            // Final pair is on the outputs this cycle.
            state_q <= StWaitDiv;
          end
        end
        StWaitDiv: begin
          if (done_parrallel_division) begin
            state_q   <= StDone;
            feed_done <= 1'b1;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pr_addr  = addr_q;
  assign deg_addr = addr_q;
  assign ip_count = ip_count_q;

endmodule
